core_register_file: RTL and testbench

.
REQ-015 data_read, pc_out and reg_h_out SHALL be combinational (asynchronous) reads of the current register contents, with no write-through bypass: a write becomes visible only after its clock edge.
REQ-016 On a rising edge with write_enable=1, register[addr_write] SHALL load bus_datain if bus_fromin=1, else data_write.
REQ-017 With write_enable=0, no register SHALL change except the PC through pc_inc; bus_fromin has no effect.
REQ-018 On a rising edge with pc_inc=1, the PC SHALL load PC+1 modulo 2^16, so 0xFFFF wraps to 0x0000.
REQ-019 pc_inc held high for N edges SHALL advance the PC by N.
REQ-020 If write_enable=1 and addr_write=15 and pc_inc=1 on the same edge, the write SHALL win: the PC loads the written value with no increment, so jumps land exactly on the target.
REQ-021 If write_enable=1 to any index other than 15 and pc_inc=1 on the same edge, both SHALL take effect.
REQ-022 Reading and writing the same index on the same cycle SHALL return the old value on data_read until the edge.
REQ-023 Inputs are sampled only at the rising edge; the block SHALL contain no other state, latency, handshake or state machine.

Reset
REQ-024 While rst=1, all 16 registers SHALL be 0x0000 immediately, independent of clk, so data_read, pc_out and reg_h_out are all 0x0000.
REQ-025 While rst=1, write_enable and pc_inc SHALL be ignored.
REQ-026 Deasserting rst SHALL take effect at the next rising edge; an assertion of rst in mid-operation SHALL discard any pending write or increment.

Verification
REQ-027 Reset, then read: assert rst; sweep addr_read over 0-15 -> data_read, pc_out and reg_h_out are all 0x0000.
REQ-028 Write and bus-select:
- write_enable=1, addr_write=3, data_write=0x1234, bus_fromin=0, one edge -> addr_read=3 gives 0x1234.
- Then bus_fromin=1, bus_datain=0xBEEF, addr_write=7 -> reg_h_out=0xBEEF after the edge and unchanged before it.
REQ-029 PC increment and wrap:
- Write 0xFFFE to index 15, then pc_inc=1 for 3 edges -> pc_out steps 0xFFFF, 0x0000, 0x0001.
- With pc_inc=0 -> pc_out holds its value.
REQ-030 Simultaneous events:
- PC=0x0010; write_enable=1, addr_write=15, data_write=0x0200, pc_inc=1 on one edge -> pc_out=0x0200.
- Same edge with addr_write=2 instead -> reg2=0x0200 and pc_out=0x0011.
REQ-031 Asynchronous reset mid-operation: with registers loaded and pc_inc=1, pulse rst between clock edges -> all outputs read 0x0000 before the next edge, and no increment occurs while rst=1.

---
 rtl/core_register_file_if.sv | 26 ++
 rtl/core_register_file.sv | 37 +++
 tb/tb_core_register_file.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/core_register_file_if.sv
// Register-file access bundle: read/write ports, write-source select, PC increment strobe.
// The master drives the request side; the slave (the register file) drives the three read outputs.
interface core_register_file_if;
  logic [3:0]  addr_read;
  logic [3:0]  addr_write;
  logic [15:0] data_write;
  logic        write_enable;
  logic [15:0] bus_datain;
  logic        bus_fromin;
  logic        pc_inc;
  logic [15:0] data_read;
  logic [15:0] pc_out;
  logic [15:0] reg_h_out;

  modport master (
    output addr_read, addr_write, data_write, write_enable,
    output bus_datain, bus_fromin, pc_inc,
    input  data_read, pc_out, reg_h_out
  );

  modport slave (
    input  addr_read, addr_write, data_write, write_enable,
    input  bus_datain, bus_fromin, pc_inc,
    output data_read, pc_out, reg_h_out
  );
endinterface

// File: rtl/core_register_file.sv
// 16x16 register file; index 7 is H and index 15 is the PC, which has a dedicated incrementer.
// Reads are combinational with no bypass, writes land on the rising edge, and there is no backpressure.
module core_register_file (
  input  logic                 clk,
  input  logic                 rst,
  core_register_file_if.slave  bus
);
  localparam logic [3:0] PC_IDX = 4'd15;
  localparam logic [3:0] H_IDX  = 4'd7;

  logic [15:0] r_regs [16];
  logic [15:0] w_wdata;
  logic        w_pc_written;

  assign w_wdata      = bus.bus_fromin ? bus.bus_datain : bus.data_write;
  assign w_pc_written = bus.write_enable && (bus.addr_write == PC_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= 16'h0000;
      end
    end else begin
      // An explicit PC write is a jump, so it suppresses the increment on that edge.
      if (bus.pc_inc && !w_pc_written) begin
        r_regs[PC_IDX] <= r_regs[PC_IDX] + 16'd1;
      end
      if (bus.write_enable) begin
        r_regs[bus.addr_write] <= w_wdata;
      end
    end
  end

  assign bus.data_read = r_regs[bus.addr_read];
  assign bus.pc_out    = r_regs[PC_IDX];
  assign bus.reg_h_out = r_regs[H_IDX];
endmodule

// File: tb/tb_core_register_file.sv
// Randomized and directed checks of core_register_file against an array-based model of the register file.
module tb_core_register_file;
  logic clk;
  logic rst;
  core_register_file_if rf ();

  core_register_file dut (
    .clk (clk),
    .rst (rst),
    .bus (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] model [16];
  int n_vec;
  int n_err;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string phase);
    check_val({phase, " data_read"}, rf.data_read, model[rf.addr_read]);
    check_val({phase, " pc_out"},    rf.pc_out,    model[15]);
    check_val({phase, " reg_h_out"}, rf.reg_h_out, model[7]);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
  endtask

  // Register-file semantics: the PC counts unless it is the write target; the write takes the selected source.
  task automatic model_edge();
    logic [15:0] nxt [16];
    if (rst) begin
      model_clear();
      return;
    end
    for (int i = 0; i < 16; i++) nxt[i] = model[i];
    if (rf.pc_inc) nxt[15] = model[15] + 16'd1;
    if (rf.write_enable) nxt[rf.addr_write] = rf.bus_fromin ? rf.bus_datain : rf.data_write;
    for (int i = 0; i < 16; i++) model[i] = nxt[i];
  endtask

  // Check old contents just before the edge, clock once, then check the new contents.
  task automatic cycle();
    #1;
    check_outputs("pre");
    @(posedge clk);
    model_edge();
    #1;
    check_outputs("post");
  endtask

  task automatic drive(input logic we, input logic [3:0] aw, input logic [15:0] dw,
                       input logic sel, input logic [15:0] bd, input logic inc, input logic [3:0] ar);
    rf.write_enable = we;
    rf.addr_write   = aw;
    rf.data_write   = dw;
    rf.bus_fromin   = sel;
    rf.bus_datain   = bd;
    rf.pc_inc       = inc;
    rf.addr_read    = ar;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_clear();
    rst = 1'b1;
    drive(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b0, 4'd0);
    #2;

    // Reset sweep, then show writes and increments are ignored while reset is held.
    for (int a = 0; a < 16; a++) begin
      rf.addr_read = 4'(a);
      #1;
      check_outputs("reset");
    end
    drive(1'b1, 4'd5, 16'hAAAA, 1'b0, 16'h5555, 1'b1, 4'd5);
    cycle();
    cycle();

    rst = 1'b0;
    drive(1'b1, 4'd3, 16'h1234, 1'b0, 16'hDEAD, 1'b0, 4'd3);
    cycle();
    check_val("wr3", rf.data_read, 16'h1234);
    drive(1'b1, 4'd7, 16'h1111, 1'b1, 16'hBEEF, 1'b0, 4'd7);
    #1;
    check_val("h_before", rf.reg_h_out, 16'h0000);
    cycle();
    check_val("h_after", rf.reg_h_out, 16'hBEEF);

    // PC wrap through 0xFFFF.
    drive(1'b1, 4'd15, 16'hFFFE, 1'b0, 16'h0, 1'b0, 4'd15);
    cycle();
    drive(1'b0, 4'd0, 16'h0, 1'b1, 16'h9999, 1'b1, 4'd15);
    cycle();
    check_val("pc_ffff", rf.pc_out, 16'hFFFF);
    cycle();
    check_val("pc_wrap", rf.pc_out, 16'h0000);
    cycle();
    check_val("pc_0001", rf.pc_out, 16'h0001);
    rf.pc_inc = 1'b0;
    cycle();
    cycle();
    check_val("pc_hold", rf.pc_out, 16'h0001);

    // Jump beats increment; a non-PC write coexists with it.
    drive(1'b1, 4'd15, 16'h0010, 1'b0, 16'h0, 1'b0, 4'd2);
    cycle();
    drive(1'b1, 4'd15, 16'h0200, 1'b0, 16'h0, 1'b1, 4'd2);
    cycle();
    check_val("jump", rf.pc_out, 16'h0200);
    drive(1'b1, 4'd15, 16'h0010, 1'b0, 16'h0, 1'b0, 4'd2);
    cycle();
    drive(1'b1, 4'd2, 16'h0200, 1'b0, 16'h0, 1'b1, 4'd2);
    cycle();
    check_val("both_r2", rf.data_read, 16'h0200);
    check_val("both_pc", rf.pc_out, 16'h0011);

    // Random traffic, including same-index read/write and the PC-write/increment collision.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
            1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) rf.addr_read = rf.addr_write;
      cycle();
    end

    // Load some state, then pulse reset between edges with an increment pending.
    drive(1'b1, 4'd15, 16'h4321, 1'b0, 16'h0, 1'b0, 4'd15);
    cycle();
    drive(1'b1, 4'd7, 16'h7777, 1'b0, 16'h0, 1'b1, 4'd7);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    for (int a = 0; a < 16; a++) begin
      rf.addr_read = 4'(a);
      #0;
      check_val("mid_rst_rd", rf.data_read, model[a]);
    end
    check_outputs("mid_rst");
    cycle();
    check_val("rst_no_inc", rf.pc_out, 16'h0000);
    rst = 1'b0;
    drive(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b1, 4'd0);
    cycle();
    check_val("pc_after_rst", rf.pc_out, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
